regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the two synchronous ports (A, B) of the dual-port register file among NREQ requesters,
//  e.g. decode rs read, decode rt read, writeback and debug. Grants up to two requests per cycle
//  using round-robin, and blocks same-address conflicts. Returns read data to the owning requester
//  one cycle after its grant. Sits between the pipeline/debug logic and the register-file RAM.
// PARAMETERS
//  DATA  18  register width in bits
//  ADDR  5   register address width; the file holds 2**ADDR entries
//  NREQ  4   number of requesters (2..8); requester index i uses slice i of the flattened buses
// PORTS
//  clk        in   1          single clock; also drives both RAM port clocks
//  rst_n      in   1          asynchronous active-low reset
//  req        in   NREQ       request valid per requester; held until granted
//  req_we     in   NREQ       1 = write, 0 = read
//  req_addr   in   NREQ*ADDR  address per requester
//  req_wdata  in   NREQ*DATA  write data per requester
//  gnt        out  NREQ       grant per requester (combinational); the access happens at this clock edge
//  rvalid     out  NREQ       read data valid per requester, one cycle after a read grant
//  rdata      out  NREQ*DATA  read data per requester; valid only while its rvalid is high
//  ram_wea    out  1          RAM port A write enable
//  ram_addra  out  ADDR       RAM port A address
//  ram_dina   out  DATA       RAM port A write data
//  ram_douta  in   DATA       RAM port A registered read data
//  ram_web    out  1          RAM port B write enable
//  ram_addrb  out  ADDR       RAM port B address
//  ram_dinb   out  DATA       RAM port B write data
//  ram_doutb  in   DATA       RAM port B registered read data
// BEHAVIOUR
//  - Round-robin pointer ptr (0..NREQ-1) gives the search order ptr, ptr+1, ... with modulo-NREQ wrap.
//  - Port A: the first requesting index in search order (winner a).
//  - Port B: the next requesting index after a in search order (candidate b).
//  - Conflict rule: b is withheld if addr(b)==addr(a) and either request is a write.
//    Same-address read/read is granted on both ports.
//  - If b is withheld, no other requester is tried for port B that cycle.
//  - gnt = onehot(a) | onehot(b). Grants are purely combinational, with no added latency.
//  - An ungranted requester keeps req asserted. Dropping req before gnt is legal and cancels the request.
//  - RAM outputs mirror the granted request; an unused port drives we=0, addr=0, din=0.
//    RAM port we = granted && req_we.
//  - ptr update at the edge: if any grant, ptr <= (last granted index + 1) mod NREQ, where last is b
//    if granted, else a; otherwise ptr holds.
//  - Read return: registered tags rd_a_idx/rd_a_vld and rd_b_idx/rd_b_vld capture read grants.
//    In the next cycle rvalid[idx]=1 and rdata slice = ram_douta (A) or ram_doutb (B).
//  - Fixed read latency is 1 cycle. Back-to-back reads by one requester return every cycle.
//  - A write is complete at its grant edge. A read granted at the next edge returns the new value.
//    The conflict rule forbids same-cycle read/write to the same address.
//  - rdata slices of non-valid requesters are 0.
//  - Reset (async, rst_n=0): ptr=0, tag valids=0, so rvalid=0 and rdata=0.
//    While rst_n=0, gnt=0 and ram_wea=ram_web=0, ram_addr*=0, ram_din*=0 regardless of req.
//  - Reset mid-read: a pending return is dropped with no rvalid. The requester must re-request.
//  - A read requester must accept rdata in its rvalid cycle; there is no backpressure.
// TESTING
//  1 Reset: rst_n=0 with all req=1 -> gnt=0, rvalid=0, ram_wea=ram_web=0. Release -> ptr=0.
//  2 Write then read: req0 write addr 3 data 18'h2A5A; next cycle req1 read addr 3 -> gnt[1].
//    Next cycle rvalid[1]=1, rdata[1]=18'h2A5A.
//  3 Dual issue: req0 read addr 1, req2 read addr 7 in the same cycle -> gnt=4'b0101, A=0, B=2.
//    Both rvalid next cycle. ptr becomes 3.
//  4 Conflict: req0 write addr 5, req1 read addr 5 -> gnt=4'b0001, ram_web=0.
//    Next cycle req1 granted and reads the new value.
//  5 Fairness: all 4 reading distinct addrs for 4 cycles -> grants {0,1},{2,3},{0,1},{2,3}.
//    No requester starves.
//  6 Reset mid-op: assert rst_n=0 in the cycle after a read grant -> rvalid stays 0.
//    After release, the first grant comes from index 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the two synchronous register-file RAM ports among NREQ requesters.
// Grants are combinational. Read data comes back to its requester one cycle after the grant.
module regfile_port_arbiter #(
    parameter int DATA = 18,
    parameter int ADDR = 5,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [NREQ*DATA-1:0] rdata,
    output logic                 ram_wea,
    output logic [ADDR-1:0]      ram_addra,
    output logic [DATA-1:0]      ram_dina,
    input  logic [DATA-1:0]      ram_douta,
    output logic                 ram_web,
    output logic [ADDR-1:0]      ram_addrb,
    output logic [DATA-1:0]      ram_dinb,
    input  logic [DATA-1:0]      ram_doutb
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr, ptr_nxt, last_idx;
    logic [PW:0]     cand;
    logic            a_found, b_found;
    logic [PW-1:0]   a_idx, b_idx;
    logic            a_gnt, b_gnt;
    logic            a_we, b_we;
    logic [ADDR-1:0] a_addr, b_addr;
    logic            rd_a_vld, rd_b_vld;
    logic [PW-1:0]   rd_a_idx, rd_b_idx;

    // Walk requesters in order ptr, ptr+1, ... ; first hit owns port A, second hit is the B candidate.
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (req[cand[PW-1:0]]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = cand[PW-1:0];
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = cand[PW-1:0];
                end
            end
        end
    end

    assign a_we   = req_we[a_idx];
    assign b_we   = req_we[b_idx];
    assign a_addr = req_addr[a_idx*ADDR +: ADDR];
    assign b_addr = req_addr[b_idx*ADDR +: ADDR];

    // A same-address pair may only share the cycle when both are reads.
    assign a_gnt = rst_n && a_found;
    assign b_gnt = rst_n && b_found && !((a_addr == b_addr) && (a_we || b_we));

    always_comb begin
        gnt = '0;
        if (a_gnt)
            gnt[a_idx] = 1'b1;
        if (b_gnt)
            gnt[b_idx] = 1'b1;
    end

    always_comb begin
        ram_wea   = a_gnt && a_we;
        ram_addra = a_gnt ? a_addr : '0;
        ram_dina  = a_gnt ? req_wdata[a_idx*DATA +: DATA] : '0;
        ram_web   = b_gnt && b_we;
        ram_addrb = b_gnt ? b_addr : '0;
        ram_dinb  = b_gnt ? req_wdata[b_idx*DATA +: DATA] : '0;
    end

    always_comb begin
        last_idx = b_gnt ? b_idx : a_idx;
        ptr_nxt  = ptr;
        if (a_gnt)
            ptr_nxt = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rd_a_vld <= 1'b0;
            rd_a_idx <= '0;
            rd_b_vld <= 1'b0;
            rd_b_idx <= '0;
        end else begin
            ptr      <= ptr_nxt;
            rd_a_vld <= a_gnt && !a_we;
            rd_a_idx <= a_idx;
            rd_b_vld <= b_gnt && !b_we;
            rd_b_idx <= b_idx;
        end
    end

    // A and B tags of one cycle always name different requesters, so the slices never collide.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (rd_a_vld) begin
            rvalid[rd_a_idx]                = 1'b1;
            rdata[rd_a_idx*DATA +: DATA]    = ram_douta;
        end
        if (rd_b_vld) begin
            rvalid[rd_b_idx]                = 1'b1;
            rdata[rd_b_idx*DATA +: DATA]    = ram_doutb;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural dual-port RAM and a read-return scoreboard.
module tb_regfile_port_arbiter;
    localparam int DATA = 18;
    localparam int ADDR = 5;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, req_we, gnt, rvalid;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_wdata, rdata;
    logic                 ram_wea, ram_web;
    logic [ADDR-1:0]      ram_addra, ram_addrb;
    logic [DATA-1:0]      ram_dina, ram_dinb, ram_douta, ram_doutb;

    logic [DATA-1:0] mem [32];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int              idx;
        logic [DATA-1:0] data;
        int              due;
    } exp_t;
    exp_t expq[$];
    logic [DATA-1:0] exp_rd [NREQ];

    regfile_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
        .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_web) mem[ram_addrb] <= ram_dinb;
        ram_douta <= mem[ram_addra];
        ram_doutb <= mem[ram_addrb];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rq(input int i, input logic we, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        req[i]                     = 1'b1;
        req_we[i]                  = we;
        req_addr[i*ADDR +: ADDR]   = a;
        req_wdata[i*DATA +: DATA]  = d;
    endtask

    task automatic all_read();
        rq(0, 1'b0, 5'd1, '0); exp_rd[0] = 18'h01111;
        rq(1, 1'b0, 5'd3, '0); exp_rd[1] = 18'h2A5A;
        rq(2, 1'b0, 5'd5, '0); exp_rd[2] = 18'h2BCDE;
        rq(3, 1'b0, 5'd7, '0); exp_rd[3] = 18'h37777;
    endtask

    // Check grant, queue expected read returns, and advance through the grant edge.
    task automatic step(input string name, input logic [NREQ-1:0] exp_gnt);
        #1;
        check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
        for (int i = 0; i < NREQ; i++)
            if (exp_gnt[i] && !req_we[i])
                expq.push_back('{i, exp_rd[i], cyc + 1});
        @(posedge clk);
        @(negedge clk);
        req = '0;
    endtask

    // Monitor: every cycle, each requester either has a due return or must be idle with zero data.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                int hit;
                hit = -1;
                for (int k = 0; k < expq.size(); k++)
                    if (hit < 0 && expq[k].idx == i && expq[k].due == cyc)
                        hit = k;
                if (hit >= 0) begin
                    check($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'd1);
                    check($sformatf("rdata[%0d]", i), 32'(rdata[i*DATA +: DATA]), 32'(expq[hit].data));
                    expq.delete(hit);
                end else begin
                    check($sformatf("idle rvalid[%0d]", i), 32'(rvalid[i]), 32'd0);
                    check($sformatf("idle rdata[%0d]", i), 32'(rdata[i*DATA +: DATA]), 32'd0);
                end
            end
            for (int k = expq.size() - 1; k >= 0; k--)
                if (expq[k].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL return timeout req%0d: got none expected %h", expq[k].idx, expq[k].data);
                    expq.delete(k);
                end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst_n     = 1'b0;
        req       = '1;
        req_we    = '1;
        req_addr  = '0;
        req_wdata = '1;
        for (int i = 0; i < NREQ; i++) exp_rd[i] = '0;

        // Reset holds everything quiet even with all requests raised.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
        check("rst wea", 32'(ram_wea), 32'd0);
        check("rst web", 32'(ram_web), 32'd0);
        check("rst dina", 32'(ram_dina), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        req_we = '0;

        // Write then read of address 3.
        rq(0, 1'b1, 5'd3, 18'h2A5A);
        #1;
        check("wr wea", 32'(ram_wea), 32'd1);
        check("wr addra", 32'(ram_addra), 32'd3);
        check("wr dina", 32'(ram_dina), 32'h2A5A);
        step("wr a3", 4'b0001);
        rq(1, 1'b0, 5'd3, '0); exp_rd[1] = 18'h2A5A;
        step("rd a3", 4'b0010);

        // Dual write on both ports, then pointer back to 0 via requester 3.
        rq(2, 1'b1, 5'd1, 18'h01111);
        rq(3, 1'b1, 5'd7, 18'h37777);
        #1;
        check("dw web", 32'(ram_web), 32'd1);
        check("dw addrb", 32'(ram_addrb), 32'd7);
        check("dw dinb", 32'(ram_dinb), 32'h37777);
        step("dual wr", 4'b1100);

        // Dual read: A=0, B=2.
        rq(0, 1'b0, 5'd1, '0); exp_rd[0] = 18'h01111;
        rq(2, 1'b0, 5'd7, '0); exp_rd[2] = 18'h37777;
        #1;
        check("dr addra", 32'(ram_addra), 32'd1);
        check("dr addrb", 32'(ram_addrb), 32'd7);
        check("dr wea", 32'(ram_wea), 32'd0);
        step("dual rd", 4'b0101);

        // Conflict: write and read to address 5; read waits one cycle and sees the new value.
        rq(0, 1'b1, 5'd5, 18'h2BCDE);
        rq(1, 1'b0, 5'd5, '0);
        #1;
        check("cf web", 32'(ram_web), 32'd0);
        check("cf addrb", 32'(ram_addrb), 32'd0);
        step("conflict", 4'b0001);
        rq(1, 1'b0, 5'd5, '0); exp_rd[1] = 18'h2BCDE;
        step("cf retry", 4'b0010);

        // Requester 3 alone moves the pointer to 0; then fairness with all four reading.
        rq(3, 1'b0, 5'd3, '0); exp_rd[3] = 18'h2A5A;
        step("rd3 alone", 4'b1000);
        all_read(); step("rr1", 4'b0011);
        all_read(); step("rr2", 4'b1100);
        all_read(); step("rr3", 4'b0011);
        all_read(); step("rr4", 4'b1100);

        // Reset right after a read grant drops the pending return.
        rq(1, 1'b0, 5'd3, '0);
        #1;
        check("mid gnt", 32'(gnt), 32'b0010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '1;
        @(negedge clk);
        #1;
        check("mid rst rvalid", 32'(rvalid), 32'd0);
        check("mid rst gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        all_read(); step("post rst", 4'b0011);
        all_read(); step("post rst 2", 4'b1100);

        repeat (3) @(negedge clk);
        #3;
        check("queue drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
